mult_acc_stage: RTL

//  Downstream consumer of the 64x64 -> 128-bit combinational multiplier output.

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_acc_stage_if.sv | 31 +++
 rtl/mult_acc_in_stage.sv | 50 +++++
 rtl/mult_acc_stage.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths and FSM encoding for the multiplier accumulate stage.
// Imported by the interface, the input register and the top.
package mult_pkg;

  localparam int PROD_W     = 128;
  localparam int ACC_W_DEF  = 136;
  localparam int CNT_W_DEF  = 9;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/mult_acc_stage_if.sv
// Product-in / group-sum-out handshake bundle; master is the producer/consumer side,
// slave is the accumulate stage.
interface mult_acc_stage_if
  import mult_pkg::*;
#(
  parameter int P_W = PROD_W,
  parameter int A_W = ACC_W_DEF,
  parameter int C_W = CNT_W_DEF
);

  logic           in_valid;
  logic           in_ready;
  logic [P_W-1:0] in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [A_W-1:0] out_data;
  logic [C_W-1:0] out_count;
  logic           out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/mult_acc_in_stage.sv
// Input register: captures a product and its last flag on every accepted beat.
// One cycle latency; never stalls, acceptance is gated only by the caller's ready.
module mult_acc_in_stage
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  output logic              accept,
  output logic              s1_valid,
  output logic [PROD_W-1:0] s1_data,
  output logic              s1_last
);

  logic              s1_valid_d, s1_valid_q;
  logic [PROD_W-1:0] s1_data_d,  s1_data_q;
  logic              s1_last_d,  s1_last_q;

  assign accept = in_valid & in_ready;

  always_comb begin
    s1_valid_d = accept;
    s1_data_d  = s1_data_q;
    s1_last_d  = s1_last_q;
    if (accept) begin
      s1_data_d = in_data;
      s1_last_d = in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_last_q  <= s1_last_d;
    end
  end

  assign s1_valid = s1_valid_q;
  assign s1_data  = s1_data_q;
  assign s1_last  = s1_last_q;

endmodule

// File: rtl/mult_acc_stage.sv
// Registers multiplier products and sums each IN_LAST-terminated group into a wide accumulator.
// 1 beat/cycle in; result valid two edges after the last beat; input held off until result taken.
module mult_acc_stage
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
)(
  input  logic           clk,
  input  logic           rst_n,
  mult_acc_stage_if.slave bus
);

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("ACC_W must be at least PROD_W");
  end

  acc_state_t        state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              accept;
  logic              s1_valid;
  logic              s1_last;
  logic [PROD_W-1:0] s1_data;
  logic              out_hs;

  logic [ACC_W-1:0]  acc_d, acc_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              ovf_d, ovf_q;
  logic [ACC_W:0]    s1_ext;
  logic [ACC_W:0]    sum_w;

  mult_acc_in_stage u_in_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .in_ready (in_ready_q),
    .in_data  (bus.in_data),
    .in_last  (bus.in_last),
    .accept   (accept),
    .s1_valid (s1_valid),
    .s1_data  (s1_data),
    .s1_last  (s1_last)
  );

  assign out_hs = out_valid_q & bus.out_ready;

  // One spare bit on the adder holds the carry that feeds the sticky overflow flag.
  assign s1_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, s1_data};
  assign sum_w  = {1'b0, acc_q} + s1_ext;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (out_hs) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (s1_valid) begin
      acc_d = sum_w[ACC_W-1:0];
      ovf_d = ovf_q | sum_w[ACC_W];
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // The first HOLD cycle lets the final sum settle before OUT_VALID rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept && bus.in_last) begin
            state_q    <= FLUSH;
            in_ready_q <= 1'b0;
          end
        end
        FLUSH: begin
          if (s1_valid && s1_last) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_hs) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule
